// File: rtl/wb_packet_scheduler_if.sv
// Bus bundle between the write-back requesters (Edge PEs + decoder) and the
// packet SRAM write-back scheduler.
interface wb_packet_scheduler_if #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 4,
  parameter int ADDR_W  = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        beat_valid;
  logic [NUM_REQ*DATA_W-1:0] beat_data;
  logic                      sram_ready;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        beat_ready;
  logic                      sram_wr_en;
  logic [ADDR_W-1:0]         sram_wr_addr;
  logic [DATA_W-1:0]         sram_wr_data;
  logic [ID_W-1:0]           owner_id;
  logic                      busy;

  // Requesters and SRAM side
  modport master (
    output req, req_len, beat_valid, beat_data, sram_ready,
    input  grant, beat_ready, sram_wr_en, sram_wr_addr, sram_wr_data, owner_id, busy
  );

  // Scheduler side
  modport slave (
    input  req, req_len, beat_valid, beat_data, sram_ready,
    output grant, beat_ready, sram_wr_en, sram_wr_addr, sram_wr_data, owner_id, busy
  );
endinterface

// File: rtl/wb_packet_scheduler.sv
// Round-robin, burst-locked arbiter for the packet SRAM write-back port.
// Optional macro WB_SCHED_DECODER_PRIO_EN gives requester 0 (decoder) absolute priority.
module wb_packet_scheduler #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 4,
  parameter int ADDR_W  = 8
) (
  input logic                clk,
  input logic                reset,
  wb_packet_scheduler_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    owner_reg, owner_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic [ADDR_W-1:0]  addr_reg, addr_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;

  logic [DATA_W-1:0]  beat_data_arr [NUM_REQ];
  logic [LEN_W-1:0]   req_len_arr   [NUM_REQ];
  logic               busy;
  logic               accept;
  logic               found;
  logic [ID_W-1:0]    winner;

  assign busy = (state_reg == BURST);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign beat_data_arr[gi] = bus.beat_data[gi*DATA_W +: DATA_W];
    assign req_len_arr[gi]   = bus.req_len[gi*LEN_W +: LEN_W];
    assign bus.beat_ready[gi] = busy && (owner_reg == ID_W'(gi)) && bus.sram_ready;
  end

  // Search index over all requesters, wrapping modulo NUM_REQ.
  function automatic logic [ID_W-1:0] rr_idx(input int base, input int k);
    int idx;
    idx = base + k;
    if (idx >= NUM_REQ) idx = idx - NUM_REQ;
    return ID_W'(idx);
  endfunction

  // Search index over PEs only (1..NUM_REQ-1); a pointer of 0 starts at PE 1.
  function automatic logic [ID_W-1:0] pe_idx(input int base, input int k);
    int idx;
    idx = ((base < 1) ? 1 : base) + k;
    if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
    return ID_W'(idx);
  endfunction

  always_comb begin
    found  = 1'b0;
    winner = '0;
`ifdef WB_SCHED_DECODER_PRIO_EN
    if (bus.req[0]) begin
      found  = 1'b1;
      winner = '0;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        if (!found && bus.req[pe_idx(int'(rr_ptr_reg), k)]) begin
          found  = 1'b1;
          winner = pe_idx(int'(rr_ptr_reg), k);
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[rr_idx(int'(rr_ptr_reg), k)]) begin
        found  = 1'b1;
        winner = rr_idx(int'(rr_ptr_reg), k);
      end
    end
`endif
  end

  assign accept = busy && bus.beat_valid[owner_reg] && bus.sram_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      remaining_reg <= '0;
      addr_reg      <= '0;
      grant_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      remaining_reg <= remaining_next;
      addr_reg      <= addr_next;
      grant_reg     <= grant_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    remaining_next = remaining_reg;
    addr_next      = addr_reg;
    grant_next     = grant_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next     = BURST;
          owner_next     = winner;
          remaining_next = req_len_arr[winner];
          grant_next     = NUM_REQ'(1) << winner;
        end
      end
      BURST: begin
        if (accept) begin
          addr_next = addr_reg + 1'b1;
          if (remaining_reg == '0) begin
            state_next = IDLE;
            grant_next = '0;
`ifdef WB_SCHED_DECODER_PRIO_EN
            // Decoder wins do not disturb the PE rotation.
            if (owner_reg != '0)
              rr_ptr_next = (owner_reg == ID_W'(NUM_REQ - 1)) ? ID_W'(1) : owner_reg + 1'b1;
`else
            rr_ptr_next = (owner_reg == ID_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
`endif
          end else begin
            remaining_next = remaining_reg - 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.grant        = grant_reg;
  assign bus.busy         = busy;
  assign bus.owner_id     = owner_reg;
  assign bus.sram_wr_en   = accept;
  assign bus.sram_wr_addr = addr_reg;
  assign bus.sram_wr_data = busy ? beat_data_arr[owner_reg] : '0;
endmodule

// File: tb/tb_wb_packet_scheduler.sv
// Directed bench for wb_packet_scheduler: reset, bursts, round-robin order,
// backpressure, address wrap and burst lock.
module tb_wb_packet_scheduler;
  localparam int NUM_REQ = 5;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 4;
  localparam int ADDR_W  = 8;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_addr = 0;

  always #5 clk = ~clk;

  wb_packet_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

  wb_packet_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_len(input int id, input int len);
    bus.req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int id);
    return DATA_W'(16'h1000 * (id + 1) + id);
  endfunction

  // One burst from a lone requester at full SRAM rate.
  task automatic burst(input int id, input int len, input bit chk);
    set_len(id, len);
    bus.req = NUM_REQ'(1) << id;
    tick();
    bus.req = '0;
    if (chk) check("grant", bus.grant, 32'(1) << id);
    for (int b = 0; b <= len; b++) begin
      if (chk) begin
        check("wr_en", bus.sram_wr_en, 1);
        check("wr_addr", bus.sram_wr_addr, exp_addr);
        check("wr_data", bus.sram_wr_data, data_of(id));
      end
      exp_addr = (exp_addr + 1) % 256;
      tick();
    end
    if (chk) begin
      check("end_grant", bus.grant, 0);
      check("end_busy", bus.busy, 0);
    end
  endtask

  int rr_exp [8];
  int rr_n;
  int drop_at;
  int writes;
  int rem;
  int n;
  logic [4:0] bp_seq;

  initial begin
    reset          = 1'b0;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.beat_valid = '0;
    bus.beat_data  = '0;
    bus.sram_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bus.beat_data[i*DATA_W +: DATA_W] = data_of(i);
    repeat (3) tick();

    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner_id, 0);
    check("rst_wr_en", bus.sram_wr_en, 0);
    check("rst_beat_ready", bus.beat_ready, 0);
    check("rst_wr_addr", bus.sram_wr_addr, 0);
    reset = 1'b1;
    tick();
    bus.beat_valid = '1;
    bus.sram_ready = 1'b1;

    // Single burst: owner 2, four beats at 0..3
    burst(2, 3, 1);

    // rr_ptr now points past owner 2
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 0);
    bus.req = 5'b11111;
    tick();
`ifdef WB_SCHED_DECODER_PRIO_EN
    check("rr_after_2", bus.grant, 5'b00001);
`else
    check("rr_after_2", bus.grant, 5'b01000);
`endif
    bus.req = '0;
    check("rr_after_2_addr", bus.sram_wr_addr, exp_addr);
    exp_addr++;
    tick();
    check("rr_after_2_busy", bus.busy, 0);

    // Reset mid-burst: owner 2 with 3 beats left
    set_len(2, 5);
    bus.req = 5'b00100;
    tick();
    bus.req = '0;
    check("mid_grant", bus.grant, 5'b00100);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_owner", bus.owner_id, 0);
    check("mid_rst_wr_en", bus.sram_wr_en, 0);
    check("mid_rst_beat_ready", bus.beat_ready, 0);
    check("mid_rst_wr_addr", bus.sram_wr_addr, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_grant", bus.grant, 0);
    exp_addr = 0;

    // Round-robin with every requester asking, single-beat bursts
`ifdef WB_SCHED_DECODER_PRIO_EN
    rr_n = 8; drop_at = 2;
    rr_exp = '{0, 0, 0, 1, 2, 3, 4, 1};
`else
    rr_n = 6; drop_at = -1;
    rr_exp = '{0, 1, 2, 3, 4, 0, 0, 0};
`endif
    for (int i = 0; i < NUM_REQ; i++) set_len(i, 0);
    bus.req = 5'b11111;
    for (int k = 0; k < rr_n; k++) begin
      tick();
      check("rr_grant", bus.grant, 32'(1) << rr_exp[k]);
      check("rr_wr_addr", bus.sram_wr_addr, exp_addr);
      exp_addr++;
      tick();
      check("rr_idle", bus.grant, 0);
      if (k == drop_at) bus.req[0] = 1'b0;
    end
    bus.req = '0;

    // Backpressure: owner 1, three beats, ready 1,0,0,1,1
    bp_seq = 5'b11001;
    writes = 0;
    set_len(1, 2);
    bus.req = 5'b00010;
    tick();
    bus.req = '0;
    check("bp_grant", bus.grant, 5'b00010);
    for (int c = 0; c < 5; c++) begin
      bus.sram_ready = bp_seq[c];
      #1;
      check("bp_beat_ready", bus.beat_ready, bp_seq[c] ? 5'b00010 : 5'b00000);
      check("bp_wr_en", bus.sram_wr_en, bp_seq[c]);
      check("bp_wr_addr", bus.sram_wr_addr, exp_addr);
      writes += int'(bus.sram_wr_en);
      if (bp_seq[c]) exp_addr++;
      tick();
    end
    bus.sram_ready = 1'b1;
    check("bp_writes", writes, 3);
    check("bp_busy", bus.busy, 0);

    // Walk the address up to 254, then a 4-beat burst wraps
    rem = 254 - exp_addr;
    while (rem > 0) begin
      n = (rem > 16) ? 16 : rem;
      burst(1, n - 1, 0);
      rem -= n;
    end
    check("pre_wrap_addr", bus.sram_wr_addr, 254);
    burst(2, 3, 1);
    check("post_wrap_addr", bus.sram_wr_addr, 2);

    // Lock: owner 3 drops req and changes len mid-burst; req[4] waits
    set_len(3, 5);
    set_len(4, 0);
    bus.req = 5'b01000;
    tick();
    check("lock_grant", bus.grant, 5'b01000);
    for (int b = 0; b < 6; b++) begin
      if (b == 2) begin
        bus.req = 5'b10000;
        set_len(3, 1);
      end
      check("lock_wr_en", bus.sram_wr_en, 1);
      check("lock_wr_addr", bus.sram_wr_addr, exp_addr);
      exp_addr++;
      tick();
    end
    check("lock_idle_grant", bus.grant, 0);
    check("lock_idle_busy", bus.busy, 0);
    tick();
    check("lock_next_grant", bus.grant, 5'b10000);
    check("lock_next_addr", bus.sram_wr_addr, exp_addr);
    bus.req = '0;
    exp_addr++;
    tick();
    check("lock_end_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
